// File: rtl/instruction_fetch_pkg.sv
// Shared defaults, FSM state type and the wrapping address increment for the fetch stage.
package instruction_fetch_pkg;

  localparam int unsigned DEF_PC_WIDTH    = 10;
  localparam int unsigned DEF_INSTR_WIDTH = 16;
  localparam int unsigned DEF_RESET_PC    = 1;
  localparam logic [15:0] DEF_HALT_WORD   = 16'hFFFF;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } fetch_state_t;

  // Successor of addr in a width-bit space; the top address wraps to reset_pc, not 0.
  // Valid for width < 32.
  function automatic logic [31:0] wrap_inc(input logic [31:0] addr,
                                           input int unsigned width,
                                           input logic [31:0] reset_pc);
    logic [31:0] last;
    last = (32'd1 << width) - 32'd1;
    return (addr == last) ? reset_pc : addr + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_pc_counter.sv
// Program counter register: redirect beats advance, advance beats hold.
module fetch_pc_counter
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned PC_WIDTH = DEF_PC_WIDTH,
  parameter int unsigned RESET_PC = DEF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_succ
);

  always_comb pc_succ = PC_WIDTH'(wrap_inc(32'(pc), PC_WIDTH, 32'(RESET_PC)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 pc <= PC_WIDTH'(RESET_PC);
    else if (redirect_valid) pc <= redirect_pc;
    else if (advance)        pc <= pc_succ;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-cycle instruction fetch stage with IF/ID register, halt detection and redirect squash.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned                PC_WIDTH    = DEF_PC_WIDTH,
  parameter int unsigned                INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int unsigned                RESET_PC    = DEF_RESET_PC,
  parameter logic [INSTR_WIDTH-1:0]     HALT_WORD   = INSTR_WIDTH'(DEF_HALT_WORD)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    pc,
  input  logic [INSTR_WIDTH-1:0] mem_instruction,
  input  logic                   redirect_valid,
  input  logic [PC_WIDTH-1:0]    redirect_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [PC_WIDTH-1:0]    out_pc_next,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  fetch_state_t        state, state_next;
  logic                load;
  logic [PC_WIDTH-1:0] pc_succ;

  fetch_pc_counter #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk            (clk),
    .rst            (rst),
    .advance        (load),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc),
    .pc_succ        (pc_succ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_next;
  end

  // A redirect squashes the load, so a halt word fetched under redirect never halts.
  always_comb begin
    load       = (state == RUN) && (!out_valid || out_ready) && !redirect_valid;
    state_next = state;
    if (redirect_valid) begin
      state_next = RUN;
    end else begin
      case (state)
        BOOT:    state_next = RUN;
        RUN:     if (load && mem_instruction == HALT_WORD) state_next = HALTED;
        HALTED:  state_next = HALTED;
        default: state_next = BOOT;
      endcase
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
      out_pc_next     <= '0;
    end else if (redirect_valid) begin
      out_valid       <= 1'b0;
    end else if (load) begin
      out_valid       <= 1'b1;
      out_instruction <= mem_instruction;
      out_pc          <= pc;
      out_pc_next     <= pc_succ;
    end else if (out_ready) begin
      out_valid       <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             fetch_count <= '0;
    else if (load && fetch_count != '1)  fetch_count <= fetch_count + 16'd1;
  end

endmodule
